// File: rtl/inst_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit and its prefetch FIFO.
package inst_fetch_unit_pkg;

  localparam int unsigned AddrW = 32;
  localparam logic [AddrW-1:0] ResetPcDefault = 32'h0000_0000;
  localparam logic [5:0] OpcHalt = 6'b010001;

  typedef enum logic [1:0] {
    StFetch,
    StWait,
    StDrain,
    StHalt
  } fetch_state_e;

  typedef struct packed {
    logic [AddrW-1:0] pc;
    logic [31:0]      inst;
  } fetch_entry_t;

  function automatic logic [AddrW-1:0] next_word(input logic [AddrW-1:0] pc);
    return pc + AddrW'(4);
  endfunction

endpackage

// File: rtl/inst_fetch_unit_fifo.sv
// Synchronous prefetch FIFO of fetch entries with flush; Depth must be a power of two.
module inst_fetch_unit_fifo
  import inst_fetch_unit_pkg::*;
#(
  parameter int unsigned Depth = 4,
  parameter int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic            flush_i,
  input  fetch_entry_t    wdata_i,
  output fetch_entry_t    rdata_o,
  output logic [CntW-1:0] count_o,
  output logic            empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  fetch_entry_t    mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            do_push;
  logic            do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CntW'(Depth)) || do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  // Storage needs no reset: the head is only consumed while count is non-zero.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: one outstanding memory read, prefetch FIFO, redirect and HALT handling.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter logic [AddrW-1:0] ResetPc    = ResetPcDefault,
  parameter int unsigned      FifoDepth  = 4,
  parameter logic [5:0]       HaltOpcode = OpcHalt
) (
  input  logic             clk,
  input  logic             reset,
  output logic             mem_req,
  output logic [AddrW-1:0] mem_addr,
  input  logic             mem_valid,
  input  logic [31:0]      mem_rdata,
  input  logic             redirect_en,
  input  logic [AddrW-1:0] redirect_pc,
  input  logic             stall,
  output logic             inst_valid,
  output logic [31:0]      inst_out,
  output logic [AddrW-1:0] inst_pc,
  output logic             halted
);

  localparam int unsigned CntW = $clog2(FifoDepth + 1);

  fetch_state_e     state_q, state_d;
  logic [AddrW-1:0] pc_q, pc_d;
  logic [AddrW-1:0] mem_addr_q, mem_addr_d;
  logic             discard_q, discard_d;
  fetch_entry_t     last_q;
  fetch_entry_t     head;
  fetch_entry_t     push_entry;
  logic             push;
  logic             pop;
  logic             flush;
  logic             fifo_empty;
  logic [CntW-1:0]  count;

  assign push_entry = '{pc: pc_q, inst: mem_rdata};

  inst_fetch_unit_fifo #(
    .Depth (FifoDepth),
    .CntW  (CntW)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .wdata_i (push_entry),
    .rdata_o (head),
    .count_o (count),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StFetch;
      pc_q       <= ResetPc;
      mem_addr_q <= '0;
      discard_q  <= 1'b0;
      last_q     <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      mem_addr_q <= mem_addr_d;
      discard_q  <= discard_d;
      if (pop) last_q <= head;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    mem_addr_d = mem_addr_q;
    discard_d  = discard_q;
    push       = 1'b0;
    flush      = 1'b0;
    if (redirect_en) begin
      flush = 1'b1;
      pc_d  = redirect_pc & ~AddrW'(3);
      // An in-flight read cannot be cancelled; its data is dropped when it lands.
      if (state_q == StWait && !mem_valid) begin
        discard_d = 1'b1;
      end else begin
        state_d   = StFetch;
        discard_d = 1'b0;
      end
    end else begin
      case (state_q)
        StFetch: begin
          if (count < CntW'(FifoDepth)) begin
            mem_addr_d = pc_q;
            state_d    = StWait;
          end
        end
        StWait: begin
          if (mem_valid) begin
            if (discard_q) begin
              discard_d = 1'b0;
              state_d   = StFetch;
            end else begin
              push    = 1'b1;
              pc_d    = next_word(pc_q);
              state_d = (mem_rdata[31:26] == HaltOpcode) ? StDrain : StFetch;
            end
          end
        end
        StDrain: begin
          if (pop && head.inst[31:26] == HaltOpcode) state_d = StHalt;
        end
        StHalt: state_d = StHalt;
        default: state_d = StFetch;
      endcase
    end
  end

  always_comb begin
    mem_req    = (state_q == StWait);
    mem_addr   = mem_addr_q;
    inst_valid = !fifo_empty;
    inst_out   = fifo_empty ? last_q.inst : head.inst;
    inst_pc    = fifo_empty ? last_q.pc : head.pc;
    pop        = !fifo_empty && !stall;
    halted     = (state_q == StHalt);
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Randomised bench for inst_fetch_unit with a transaction-level instruction stream model.
module tb_inst_fetch_unit;

  localparam int Depth = 4;

  logic        clk         = 1'b0;
  logic        reset       = 1'b1;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_valid   = 1'b0;
  logic [31:0] mem_rdata   = '0;
  logic        redirect_en = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        stall       = 1'b0;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        halted;

  inst_fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_valid   (mem_valid),
    .mem_rdata   (mem_rdata),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .inst_valid  (inst_valid),
    .inst_out    (inst_out),
    .inst_pc     (inst_pc),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Program image and expected architectural stream.
  logic [31:0] halt_addr = 32'h1;
  logic [31:0] exp_fetch_addr, exp_pop_pc, last_pc, last_inst, held_addr;
  int          buffered;
  bit          outstanding, discard, stopped, exp_halted;
  int          age, lat_cur;
  int          lat_lo = 2, lat_hi = 2;
  bit          stall_force = 0, rnd_stall = 0, spurious = 0, redir_now = 0;
  int          redir_pct = 0;
  logic [31:0] redir_tgt = '0;
  logic [31:0] redir_mask = 32'h7F;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] inst_at(input logic [31:0] a);
    if (a == halt_addr) return {6'b010001, 26'h0};
    return 32'h2000_0000 + a;
  endfunction

  task automatic do_reset(input logic [31:0] haddr);
    reset       = 1'b0;
    mem_valid   = 1'b0;
    redirect_en = 1'b0;
    stall       = 1'b0;
    #1;
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_inst_valid", inst_valid, 0);
    check("rst_inst_out", inst_out, 0);
    check("rst_inst_pc", inst_pc, 0);
    check("rst_halted", halted, 0);
    @(negedge clk);
    @(negedge clk);
    reset          = 1'b1;
    halt_addr      = haddr;
    exp_fetch_addr = '0;
    exp_pop_pc     = '0;
    last_pc        = '0;
    last_inst      = '0;
    buffered       = 0;
    outstanding    = 0;
    discard        = 0;
    stopped        = 0;
    exp_halted     = 0;
  endtask

  task automatic step();
    bit          pop, got, fire;
    logic [31:0] tgt;
    @(negedge clk);
    check("inst_valid", inst_valid, buffered != 0);
    if (buffered != 0) begin
      check("inst_pc", inst_pc, exp_pop_pc);
      check("inst_out", inst_out, inst_at(exp_pop_pc));
    end else begin
      check("hold_pc", inst_pc, last_pc);
      check("hold_inst", inst_out, last_inst);
    end
    check("halted", halted, exp_halted);
    if (stopped || buffered == Depth) check("req_gated", mem_req, 0);
    if (mem_req && !outstanding) begin
      check("req_addr", mem_addr, exp_fetch_addr);
      outstanding = 1;
      held_addr   = mem_addr;
      age         = 0;
      lat_cur     = $urandom_range(lat_hi, lat_lo);
    end else if (outstanding) begin
      check("req_held", mem_req, 1);
      if (mem_req) begin
        check("req_addr_stable", mem_addr, held_addr);
        age++;
      end else begin
        outstanding = 0;
      end
    end

    mem_valid = outstanding && (age >= lat_cur);
    mem_rdata = mem_valid ? inst_at(held_addr) : $urandom();
    if (!outstanding && spurious && $urandom_range(0, 5) == 0) mem_valid = 1'b1;
    stall = stall_force || (rnd_stall && $urandom_range(0, 2) == 0);
    fire  = redir_now || (redir_pct > 0 && $urandom_range(0, 99) < redir_pct);
    tgt   = redir_now ? redir_tgt : ($urandom() & redir_mask);
    redir_now   = 0;
    redirect_en = fire;
    redirect_pc = tgt;

    pop = (buffered != 0) && !stall;
    got = outstanding && mem_valid;
    if (pop) begin
      last_pc   = exp_pop_pc;
      last_inst = inst_at(exp_pop_pc);
      if (exp_pop_pc == halt_addr) exp_halted = 1;
      exp_pop_pc = exp_pop_pc + 32'd4;
      buffered--;
    end
    if (fire) begin
      exp_fetch_addr = tgt & ~32'h3;
      exp_pop_pc     = exp_fetch_addr;
      buffered       = 0;
      exp_halted     = 0;
      stopped        = 0;
      discard        = outstanding && !mem_valid;
    end else if (got) begin
      if (discard) begin
        discard = 0;
      end else begin
        buffered++;
        if (exp_fetch_addr == halt_addr) stopped = 1;
        exp_fetch_addr = exp_fetch_addr + 32'd4;
      end
    end
    if (got) outstanding = 0;
  endtask

  // Advance until a fresh request using the current latency setting is in flight.
  task automatic wait_fresh_req();
    for (int i = 0; i < 40; i++) begin
      if (outstanding && age == 0 && lat_cur == lat_hi) break;
      step();
    end
    check("wait_req_timeout", outstanding, 1);
  endtask

  initial begin
    #2;
    do_reset(32'h1);
    repeat (30) step();

    // Back-pressure: FIFO fills to Depth and fetch stops until released.
    do_reset(32'h1);
    stall_force = 1;
    repeat (20) step();
    check("stall_no_req", mem_req, 0);
    check("stall_valid", inst_valid, 1);
    stall_force = 0;
    repeat (30) step();

    // Redirect while a read is in flight: its data must be dropped.
    lat_lo = 3;
    lat_hi = 3;
    wait_fresh_req();
    redir_tgt = 32'h103;
    redir_now = 1;
    step();
    repeat (20) step();

    // HALT word at 0x8.
    lat_lo = 2;
    lat_hi = 2;
    do_reset(32'h8);
    repeat (40) step();
    check("halt_flag", halted, 1);
    check("halt_opcode", inst_out[31:26], 6'b010001);
    check("halt_pc", inst_pc, 32'h8);
    check("halt_no_valid", inst_valid, 0);

    // Redirect out of HALT.
    redir_tgt = 32'h200;
    redir_now = 1;
    step();
    repeat (20) step();
    check("resume_halted", halted, 0);

    // Asynchronous reset while a request is pending.
    lat_lo = 3;
    lat_hi = 3;
    wait_fresh_req();
    #2;
    do_reset(32'h1);
    repeat (10) step();

    // Randomised traffic with redirects, stalls, stray valids and HALTs.
    lat_lo     = 0;
    lat_hi     = 3;
    rnd_stall  = 1;
    spurious   = 1;
    redir_pct  = 3;
    redir_mask = 32'h7F;
    do_reset(32'h40);
    repeat (3000) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
